// File: rtl/uart_text_pkg.sv
// Shared constants and encodings for the UART text writer.
// Imported by the cursor and the top-level writer.
package uart_text_pkg;

    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_FF  = 8'h0C;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] PRINT_MIN = 8'h20;
    localparam logic [7:0] PRINT_MAX = 8'h7E;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE_WRAP,
        S_FILL
    } state_e;

    typedef enum logic [2:0] {
        CUR_NONE,
        CUR_ADVANCE,
        CUR_NEWLINE,
        CUR_RETURN,
        CUR_BACK,
        CUR_HOME
    } cur_op_e;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_MIN) && (b <= PRINT_MAX);
    endfunction

endpackage

// File: rtl/uart_text_writer_cursor.sv
// Text cursor: row, column, row base and linear address kept in step
// by increments only, so no multiplier is needed.
module text_cursor
    import uart_text_pkg::*;
#(
    parameter int RAM_BITS = 13,
    parameter int NUM_COLS = 80,
    parameter int NUM_ROWS = 80,
    parameter int COL_BITS = 7,
    parameter int ROW_BITS = 7
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  cur_op_e             op_i,
    output logic [COL_BITS-1:0] col_o,
    output logic [ROW_BITS-1:0] row_o,
    output logic [RAM_BITS-1:0] addr_o,
    output logic [RAM_BITS-1:0] base_o,
    output logic [RAM_BITS-1:0] nl_base_o,
    output logic                last_col_o
);

    localparam logic [RAM_BITS-1:0] COLS_A  = RAM_BITS'(NUM_COLS);
    localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'(NUM_COLS - 1);
    localparam logic [ROW_BITS-1:0] ROW_MAX = ROW_BITS'(NUM_ROWS - 1);

    logic [COL_BITS-1:0] col_q, col_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [RAM_BITS-1:0] base_q, base_d;
    logic [RAM_BITS-1:0] addr_q, addr_d;
    logic                last_row;
    logic                wrap;

    assign last_row   = (row_q == ROW_MAX);
    assign last_col_o = (col_q == COL_MAX);
    assign nl_base_o  = last_row ? '0 : base_q + COLS_A;
    assign wrap       = (op_i == CUR_NEWLINE) ||
                        ((op_i == CUR_ADVANCE) && last_col_o);

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign addr_o = addr_q;
    assign base_o = base_q;

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        base_d = base_q;
        addr_d = addr_q;
        if (wrap) begin
            col_d  = '0;
            row_d  = last_row ? '0 : row_q + 1'b1;
            base_d = nl_base_o;
            addr_d = nl_base_o;
        end else begin
            unique case (op_i)
                CUR_ADVANCE: begin
                    col_d  = col_q + 1'b1;
                    addr_d = addr_q + 1'b1;
                end
                CUR_RETURN: begin
                    col_d  = '0;
                    addr_d = base_q;
                end
                CUR_BACK: begin
                    if (col_q != '0) begin
                        col_d  = col_q - 1'b1;
                        addr_d = addr_q - 1'b1;
                    end
                end
                CUR_HOME: begin
                    col_d  = '0;
                    row_d  = '0;
                    base_d = '0;
                    addr_d = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q  <= '0;
            row_q  <= '0;
            base_q <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            base_q <= base_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/uart_text_writer.sv
// Terminal-style writer: UART bytes become character RAM writes at a
// hardware cursor, with LF/CR/BS/FF handling and row blanking.
module uart_text_writer
    import uart_text_pkg::*;
#(
    parameter int          RAM_BITS   = 13,
    parameter int          NUM_COLS   = 80,
    parameter int          NUM_ROWS   = 80,
    parameter int          COL_BITS   = 7,
    parameter int          ROW_BITS   = 7,
    parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          uart_data,
    input  logic                uart_data_stb,
    output logic [RAM_BITS-1:0] ram_addr,
    output logic [7:0]          ram_data,
    output logic                ram_stb,
    output logic [COL_BITS-1:0] cursor_col,
    output logic [ROW_BITS-1:0] cursor_row,
    output logic                busy,
    output logic                overrun
);

    localparam logic [RAM_BITS-1:0] COLS_M1  = RAM_BITS'(NUM_COLS - 1);
    localparam logic [RAM_BITS-1:0] CELLS_M1 = RAM_BITS'(NUM_COLS * NUM_ROWS - 1);

    state_e              state_q;
    logic [RAM_BITS-1:0] fill_addr_q;
    logic [RAM_BITS-1:0] fill_rem_q;
    logic [RAM_BITS-1:0] ram_addr_q;
    logic [7:0]          ram_data_q;
    logic                ram_stb_q;
    logic                busy_q;
    logic                overrun_q;

    logic                accept;
    cur_op_e             op;
    logic [RAM_BITS-1:0] cur_addr;
    logic [RAM_BITS-1:0] cur_base;
    logic [RAM_BITS-1:0] nl_base;
    logic                last_col;

    assign accept = uart_data_stb && !busy_q;

    always_comb begin
        op = CUR_NONE;
        if (accept) begin
            if (is_printable(uart_data)) begin
                op = CUR_ADVANCE;
            end else begin
                unique case (uart_data)
                    ASCII_LF: op = CUR_NEWLINE;
                    ASCII_CR: op = CUR_RETURN;
                    ASCII_BS: op = CUR_BACK;
                    ASCII_FF: op = CUR_HOME;
                    default:  op = CUR_NONE;
                endcase
            end
        end
    end

    text_cursor #(
        .RAM_BITS (RAM_BITS),
        .NUM_COLS (NUM_COLS),
        .NUM_ROWS (NUM_ROWS),
        .COL_BITS (COL_BITS),
        .ROW_BITS (ROW_BITS)
    ) u_cursor (
        .clk_i      (clk),
        .rst_i      (rst),
        .op_i       (op),
        .col_o      (cursor_col),
        .row_o      (cursor_row),
        .addr_o     (cur_addr),
        .base_o     (cur_base),
        .nl_base_o  (nl_base),
        .last_col_o (last_col)
    );

    // The first clear of every fill is issued from the starting state,
    // so fill_rem_q counts the writes still to come after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            fill_addr_q <= '0;
            fill_rem_q  <= '0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            ram_stb_q   <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            ram_stb_q <= 1'b0;
            if (uart_data_stb && busy_q) begin
                overrun_q <= 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    unique case (op)
                        CUR_ADVANCE: begin
                            ram_stb_q  <= 1'b1;
                            ram_addr_q <= cur_addr;
                            ram_data_q <= uart_data;
                            if (last_col) begin
                                busy_q  <= 1'b1;
                                state_q <= S_WRITE_WRAP;
                            end
                        end
                        CUR_NEWLINE: begin
                            ram_stb_q   <= 1'b1;
                            ram_addr_q  <= nl_base;
                            ram_data_q  <= CLEAR_CHAR;
                            fill_addr_q <= nl_base + 1'b1;
                            fill_rem_q  <= COLS_M1;
                            busy_q      <= 1'b1;
                            state_q     <= S_FILL;
                        end
                        CUR_HOME: begin
                            ram_stb_q   <= 1'b1;
                            ram_addr_q  <= '0;
                            ram_data_q  <= CLEAR_CHAR;
                            fill_addr_q <= RAM_BITS'(1);
                            fill_rem_q  <= CELLS_M1;
                            busy_q      <= 1'b1;
                            state_q     <= S_FILL;
                        end
                        default: ;
                    endcase
                end
                S_WRITE_WRAP: begin
                    ram_stb_q   <= 1'b1;
                    ram_addr_q  <= cur_base;
                    ram_data_q  <= CLEAR_CHAR;
                    fill_addr_q <= cur_base + 1'b1;
                    fill_rem_q  <= COLS_M1;
                    state_q     <= S_FILL;
                end
                S_FILL: begin
                    if (fill_rem_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        ram_stb_q   <= 1'b1;
                        ram_addr_q  <= fill_addr_q;
                        ram_data_q  <= CLEAR_CHAR;
                        fill_addr_q <= fill_addr_q + 1'b1;
                        fill_rem_q  <= fill_rem_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_data = ram_data_q;
    assign ram_stb  = ram_stb_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule

// File: doc/uart_text_writer.md
Name: uart_text_writer

Overview:
Terminal-style successor to the single-byte UART-to-RAM forwarder. It takes received UART bytes and writes printable characters into the character RAM at a hardware cursor. The cursor address is kept equal to row*NUM_COLS+col by increments only, with no multiplier. It also interprets control codes (LF, CR, BS, FF) and blanks each row as the cursor enters it. It sits between the UART receiver and the character RAM that feeds the CRT text renderer.

Parameters:
RAM_BITS, 13, width of ram_addr; NUM_COLS*NUM_ROWS must be <= 2**RAM_BITS.
NUM_COLS, 80, characters per row; must be >= 2.
NUM_ROWS, 80, rows per screen; must be >= 2.
COL_BITS, 7, cursor column width; 2**COL_BITS >= NUM_COLS.
ROW_BITS, 7, cursor row width; 2**ROW_BITS >= NUM_ROWS.
CLEAR_CHAR, 8'h20, byte written when blanking.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
uart_data  in  8  received byte, valid when uart_data_stb=1
uart_data_stb  in  1  one-cycle byte-valid strobe
ram_addr  out  RAM_BITS  RAM write address
ram_data  out  8  RAM write data
ram_stb  out  1  one-cycle write strobe; one write per high cycle
cursor_col  out  COL_BITS  current column
cursor_row  out  ROW_BITS  current row
busy  out  1  high while a fill is in progress; bytes are not accepted
overrun  out  1  sticky; set when a strobe arrives while busy

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs 0, cursor (0,0), internal cursor address 0, state S_IDLE. Reset mid-fill aborts the fill; RAM contents are left as they are.
- Acceptance: a byte is accepted in cycle N when uart_data_stb=1 and busy=0. All outputs are registered, so effects appear at N+1.
- Printable byte (0x20..0x7E):
  - N+1: ram_stb=1, ram_addr=old cursor address, ram_data=byte; col+1 and address+1.
  - Not at col NUM_COLS-1: busy stays 0, so back-to-back bytes are legal every cycle.
  - At col NUM_COLS-1: the character is written at N+1, the cursor moves to (row+1,0), and a row fill follows (busy=1 from N+1).
- LF (0x0A): cursor moves to (row+1,0) at N+1; a row fill of the new row occupies N+1..N+NUM_COLS.
- CR (0x0D): col=0 and address -= col at N+1; no write.
- BS (0x08): if col>0, col-1 and address-1; at col 0, no change. No write.
- FF (0x0C): cursor (0,0) at N+1; screen fill writes addresses 0..NUM_COLS*NUM_ROWS-1 over N+1..N+NUM_COLS*NUM_ROWS.
- Other bytes (0x00..0x1F except the above, and 0x7F..0xFF): ignored; no write, no cursor change.
- Row wrap: advancing past row NUM_ROWS-1 goes to row 0, address 0, and row 0 is blanked. There is no scrolling.
- Row fill: NUM_COLS consecutive ram_stb cycles writing CLEAR_CHAR to new_row_base+0..NUM_COLS-1, in ascending order.
- busy: 1 from the first fill cycle through the last fill write inclusive; 0 on the following cycle.
- Strobe while busy: the byte is dropped, overrun goes 1 next cycle, and the fill continues unaffected.
- States: S_IDLE → S_FILL (LF, FF, or a printable at the last column). S_FILL → S_IDLE after the final write. The char-write-then-fill sequence for a printable at the last column is one S_WRITE_WRAP cycle followed by S_FILL.
- Invariants:
  - cursor_col < NUM_COLS and cursor_row < NUM_ROWS at all times.
  - In S_IDLE, the internal cursor address == row*NUM_COLS+col.

Decomposition:
- Shared package uart_text_pkg: ASCII constants (ASCII_LF, ASCII_CR, ASCII_BS, ASCII_FF, PRINT_MIN, PRINT_MAX) and the state encoding (S_IDLE, S_WRITE_WRAP, S_FILL).
- One sub-module, text_cursor: holds row, col, row_base and the address. Operations are advance, newline, return, back, home. It owns wrap logic and the multiplier-free invariant, so it is reusable by a future scrollback block.

Test Plan:
- After reset, byte 0x41 → N+1: ram_stb=1, addr 0, data 0x41; cursor (0,1); busy=0. Then 0x42 next cycle → addr 1.
- "ABCDE" then LF → 80 writes of 0x20 at addrs 80..159; busy=1 for exactly 80 cycles; cursor (1,0); next 0x41 → addr 80.
- Cursor (0,3): BS → col 2, no ram_stb. At col 0, BS → unchanged. CR from (2,7) → (2,0), address 160.
- Cursor (79,79), byte 0x5A → write 0x5A at addr 6399, then 80 clears at addrs 0..79; cursor (0,0).
- FF → 6400 writes of 0x20 at addrs 0..6399; busy deasserts the cycle after addr 6399. A strobe mid-fill → byte dropped, overrun=1 and stays 1.
- Assert rst mid-row-fill → outputs 0 immediately; after release, byte 0x41 → addr 0. Byte 0x07 → no write.
